// File: rtl/seg_scan_decoder.sv
// Receive-side decoder for a multiplexed active-low 7-segment scan bus.
// Qualifies each digit dwell for stability and rebuilds the hex word with a frame strobe.
module seg_scan_decoder #(
  parameter int DIGITS        = 8,
  parameter int STABLE_CYCLES = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [7:0]            seg_in,
  input  logic [DIGITS-1:0]     an_in,
  output logic [4*DIGITS-1:0]   word_out,
  output logic [DIGITS-1:0]     dp_out,
  output logic [DIGITS-1:0]     blank_out,
  output logic                  frame_valid,
  output logic                  err_pattern,
  output logic                  err_anode
);

  localparam int W = 4 * DIGITS;

  logic [DIGITS-1:0] an_r_q, an_r_d;
  logic [7:0]        seg_r_q, seg_r_d;
  logic [7:0]        cnt_q, cnt_d;
  logic [DIGITS-1:0] seen_q, seen_d;
  logic [W-1:0]      word_sh_q, word_sh_d;
  logic [DIGITS-1:0] dp_sh_q, dp_sh_d;
  logic [DIGITS-1:0] blank_sh_q, blank_sh_d;
  logic [W-1:0]      word_out_q, word_out_d;
  logic [DIGITS-1:0] dp_out_q, dp_out_d;
  logic [DIGITS-1:0] blank_out_q, blank_out_d;
  logic              frame_valid_q, frame_valid_d;
  logic              err_pattern_q, err_pattern_d;
  logic              err_anode_q, err_anode_d;

  logic [DIGITS-1:0] an_low;
  logic [DIGITS-1:0] seen_upd;
  logic              multi_low, one_low, match, capture, frame_done;
  logic [3:0]        nib;
  logic              recognised, blank_pat;

  // Segment pattern to nibble; unknown patterns decode as 0 and are flagged.
  always_comb begin
    nib        = 4'h0;
    recognised = 1'b1;
    blank_pat  = 1'b0;
    case (seg_in[6:0])
      7'h40: nib = 4'h0;
      7'h79: nib = 4'h1;
      7'h24: nib = 4'h2;
      7'h30: nib = 4'h3;
      7'h19: nib = 4'h4;
      7'h12: nib = 4'h5;
      7'h02: nib = 4'h6;
      7'h78: nib = 4'h7;
      7'h00: nib = 4'h8;
      7'h18: nib = 4'h9;
      7'h08: nib = 4'hA;
      7'h03: nib = 4'hB;
      7'h46: nib = 4'hC;
      7'h21: nib = 4'hD;
      7'h06: nib = 4'hE;
      7'h0E: nib = 4'hF;
      7'h7F: blank_pat = 1'b1;
      default: recognised = 1'b0;
    endcase
  end

  always_comb begin
    an_low    = ~an_in;
    multi_low = (an_low & (an_low - DIGITS'(1))) != '0;
    one_low   = (an_low != '0) && !multi_low;
    match     = (an_in == an_r_q) && (seg_in == seg_r_q);
    capture   = match && one_low && (cnt_q == 8'(STABLE_CYCLES - 1));
    seen_upd  = seen_q | an_low;
    frame_done = capture && (&seen_upd);

    an_r_d  = an_in;
    seg_r_d = seg_in;

    // Blanking and multi-anode cycles break a dwell just like a mismatch.
    if (!match || !one_low)
      cnt_d = 8'd0;
    else if (cnt_q != 8'(STABLE_CYCLES))
      cnt_d = cnt_q + 8'd1;
    else
      cnt_d = cnt_q;

    word_sh_d  = word_sh_q;
    dp_sh_d    = dp_sh_q;
    blank_sh_d = blank_sh_q;
    if (capture) begin
      for (int i = 0; i < DIGITS; i++) begin
        if (an_low[i]) begin
          word_sh_d[4*i +: 4] = nib;
          dp_sh_d[i]          = ~seg_in[7];
          blank_sh_d[i]       = blank_pat;
        end
      end
    end

    if (frame_done)
      seen_d = '0;
    else if (capture)
      seen_d = seen_upd;
    else
      seen_d = seen_q;

    word_out_d    = frame_done ? word_sh_d  : word_out_q;
    dp_out_d      = frame_done ? dp_sh_d    : dp_out_q;
    blank_out_d   = frame_done ? blank_sh_d : blank_out_q;
    frame_valid_d = frame_done;
    err_pattern_d = capture && !recognised;
    err_anode_d   = multi_low;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      an_r_q        <= '0;
      seg_r_q       <= '0;
      cnt_q         <= '0;
      seen_q        <= '0;
      word_sh_q     <= '0;
      dp_sh_q       <= '0;
      blank_sh_q    <= '0;
      word_out_q    <= '0;
      dp_out_q      <= '0;
      blank_out_q   <= '0;
      frame_valid_q <= 1'b0;
      err_pattern_q <= 1'b0;
      err_anode_q   <= 1'b0;
    end else begin
      an_r_q        <= an_r_d;
      seg_r_q       <= seg_r_d;
      cnt_q         <= cnt_d;
      seen_q        <= seen_d;
      word_sh_q     <= word_sh_d;
      dp_sh_q       <= dp_sh_d;
      blank_sh_q    <= blank_sh_d;
      word_out_q    <= word_out_d;
      dp_out_q      <= dp_out_d;
      blank_out_q   <= blank_out_d;
      frame_valid_q <= frame_valid_d;
      err_pattern_q <= err_pattern_d;
      err_anode_q   <= err_anode_d;
    end
  end

  assign word_out    = word_out_q;
  assign dp_out      = dp_out_q;
  assign blank_out   = blank_out_q;
  assign frame_valid = frame_valid_q;
  assign err_pattern = err_pattern_q;
  assign err_anode   = err_anode_q;

endmodule

// File: doc/seg_scan_decoder.md
Name: seg_scan_decoder

Overview:
- Receive-side counterpart of the hex-to-7-segment encoder.
- Samples a multiplexed, active-low 7-segment scan bus (segment lines plus per-digit anodes), qualifies each digit dwell for stability, and decodes each segment pattern back to a hex nibble.
- Assembles a full DIGITS-wide hex word with a frame-valid strobe.
- Used in board self-test to read back the RSA result display and check it against the expected ciphertext/plaintext.

Parameters:
- DIGITS, 8: number of multiplexed digits; word width is 4*DIGITS.
- STABLE_CYCLES, 4: number of consecutive matching samples required after the first sample before a digit is captured; legal range 1..255.

Ports:
- clk  input  1  system clock; all logic on the rising edge.
- rst  input  1  synchronous, active-high reset.
- seg_in  input  8  active-low segments; bit7 = DP, bits[6:0] = g..a.
- an_in  input  DIGITS  active-low anodes; bit i low selects digit i.
- word_out  output  4*DIGITS  decoded word; digit i occupies bits [4i+3:4i].
- dp_out  output  DIGITS  DP lit (1) per digit, latched with the word.
- blank_out  output  DIGITS  digit was blank (seg[6:0]=7'h7F), latched with the word.
- frame_valid  output  1  one-cycle pulse when word_out, dp_out and blank_out update.
- err_pattern  output  1  one-cycle pulse when an unrecognised pattern is captured.
- err_anode  output  1  one-cycle pulse when more than one anode is low.

Behaviour:
- Reset, on rising clk with rst=1: all outputs 0; sample registers, stability counter, seen mask and shadow word cleared. Reset mid-frame discards any partial frame.
- Sampling: (an_in, seg_in) registered every cycle into (an_r, seg_r).
- Match: the current input equals (an_r, seg_r).
- Stability counter cnt:
  - cleared on mismatch;
  - incremented on match;
  - saturates at STABLE_CYCLES.
- Capture: occurs on the edge where match is true, an_in has exactly one low bit, and cnt == STABLE_CYCLES-1. This gives exactly one capture per dwell.
- Latency: input held constant at edges t..t+STABLE_CYCLES is captured at edge t+STABLE_CYCLES. A dwell of STABLE_CYCLES or fewer samples is ignored, which rejects glitches.
- Anode rules:
  - all anodes high = legal inter-digit blanking; counter kept clear, no capture, no error;
  - two or more anodes low: err_anode pulses on every such edge, counter cleared, no capture.
- Decode of seg[6:0] → nibble:
  - 40→0, 79→1, 24→2, 30→3, 19→4, 12→5, 02→6, 78→7, 00→8, 18→9, 08→A, 03→B, 46→C, 21→D, 06→E, 0E→F.
  - 7F → nibble 0 with blank bit set.
  - Any other pattern → nibble 0, err_pattern pulses on the capture edge; the digit still counts as seen.
  - dp = ~seg[7].
- Capture action: writes the nibble, dp and blank bits for digit i into shadow registers and sets seen[i].
  - A repeat capture of an already-seen digit before the frame completes overwrites its shadow entry; the seen mask is unchanged.
- Frame completion: on the capture edge where the seen mask becomes all ones:
  - word_out, dp_out and blank_out are loaded from the shadow (including this digit) at that same edge;
  - frame_valid is high for the following cycle;
  - the seen mask is cleared at that edge.
- Between frames, outputs hold their last values.
- Digit scan order is arbitrary; no ordering is required.
- Simultaneous events: frame completion and err_pattern may pulse together; the bad digit appears as nibble 0 in word_out.

Test Plan:
- DIGITS=8, STABLE_CYCLES=4; scan 0x1234ABCD with 6-cycle dwells, digits 0..7, one blank cycle between digits, DP off → single frame_valid pulse; word_out=32'h1234ABCD, dp_out=0, blank_out=0, no errors.
- Repeat the scan with digit 3 showing seg 8'h7F and digit 5 with seg 8'h40 → blank_out[3]=1, nibble 3 = 0, nibble 5 = 0.
- During the scan, hold digit 2 on seg 8'h7E (invalid) for 6 cycles → err_pattern pulses once on the capture edge; the frame still completes with nibble 2 = 0.
- Glitch test: present digit 4 = 0x88 for 4 cycles only (STABLE_CYCLES samples), then switch → no capture of that value; seen[4] stays clear and no frame_valid until a valid dwell occurs.
- Drive an_in=8'hFC (two anodes low) for 3 cycles → err_anode high on 3 consecutive cycles, no capture.
- Capture digits 0..5, assert rst for 1 cycle, then scan a full 0xCAFE0001 → all outputs 0 after reset; a single frame_valid with word_out=32'hCAFE0001 and no stale digits merged.
